// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one shift step per clock.
// Produces four registered decimal digits; values above 9999 saturate to 9999 with overflow set.
module bin_to_bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [BIN_W-1:0] bin_reg;
  logic [15:0]      scratch_reg;
  logic [15:0]      scratch_adj;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;

  // Add-3 correction on every BCD nibble that would exceed 9 after doubling.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                    ? scratch_reg[gi*4 +: 4] + 4'd3
                                    : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      bin_reg     <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      ones        <= 4'd0;
      tens        <= 4'd0;
      hundreds    <= 4'd0;
      thousands   <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg     <= bin;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= (32'(bin) > 32'd9999);
            busy        <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_reg <= {scratch_adj[14:0], bin_reg[BIN_W-1]};
          bin_reg     <= bin_reg << 1;
          cnt_reg     <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(BIN_W - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          // The 16-bit scratch cannot represent a fifth digit, so saturate instead.
          if (ovf_reg) begin
            ones      <= 4'd9;
            tens      <= 4'd9;
            hundreds  <= 4'd9;
            thousands <= 4'd9;
          end else begin
            ones      <= scratch_reg[3:0];
            tens      <= scratch_reg[7:4];
            hundreds  <= scratch_reg[11:8];
            thousands <= scratch_reg[15:12];
          end
          overflow  <= ovf_reg;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and sweep bench for bin_to_bcd_seq: one main DUT, four parallel sweep lanes
// splitting 0..9999, and a 4-bit instance for the narrow-width sweep.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic [3:0]  ones, tens, hundreds, thousands;
  logic        busy, done, overflow;

  logic        sw_start;
  logic [13:0] sw_bin       [4];
  logic [3:0]  sw_ones      [4];
  logic [3:0]  sw_tens      [4];
  logic [3:0]  sw_hundreds  [4];
  logic [3:0]  sw_thousands [4];
  logic        sw_busy      [4];
  logic        sw_done      [4];
  logic        sw_ovf       [4];

  logic        w4_start;
  logic [3:0]  w4_bin;
  logic [3:0]  w4_ones, w4_tens, w4_hundreds, w4_thousands;
  logic        w4_busy, w4_done, w4_ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(14)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .busy(busy), .done(done), .overflow(overflow)
  );

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      bin_to_bcd_seq #(.BIN_W(14)) u_lane (
        .clk(clk), .reset(reset), .start(sw_start), .bin(sw_bin[gi]),
        .ones(sw_ones[gi]), .tens(sw_tens[gi]), .hundreds(sw_hundreds[gi]),
        .thousands(sw_thousands[gi]), .busy(sw_busy[gi]), .done(sw_done[gi]),
        .overflow(sw_ovf[gi])
      );
    end
  endgenerate

  bin_to_bcd_seq #(.BIN_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .start(w4_start), .bin(w4_bin),
    .ones(w4_ones), .tens(w4_tens), .hundreds(w4_hundreds), .thousands(w4_thousands),
    .busy(w4_busy), .done(w4_done), .overflow(w4_ovf)
  );

  // Decimal reference: digits of v packed thousands..ones.
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {thousands, hundreds, tens, ones};
  endfunction

  // Advance negedges until done is seen or the budget runs out.
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 40);
  endtask

  task automatic test_reset();
    int c;
    reset = 1'b1; start = 1'b1; bin = 14'd1234;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, overflow} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, overflow});
    else pass_cnt++;
    total_cnt++;
    if (digits() !== 16'h0000) $display("FAIL reset_digits: got %h want 0000", digits());
    else pass_cnt++;
    reset = 1'b0; bin = 14'd99;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL reset_first_start_busy: got %b want 1", busy);
    else pass_cnt++;
    wait_done(c);
    total_cnt++;
    if (digits() !== 16'h0099 || c != 15) $display("FAIL reset_first_conv: got %h lat %0d want 0099 lat 15", digits(), c);
    else pass_cnt++;
    $display("conv bin=99 -> %h latency %0d", digits(), c);
  endtask

  task automatic test_basic();
    int c;
    bin = 14'd1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL basic_busy: got busy %b done %b want 1 0", busy, done);
    else pass_cnt++;
    total_cnt++;
    if (digits() !== 16'h0099) $display("FAIL basic_hold_prev: got %h want 0099", digits());
    else pass_cnt++;
    wait_done(c);
    total_cnt++;
    if (c != 15) $display("FAIL basic_latency: got %0d want 15", c);
    else pass_cnt++;
    total_cnt++;
    if (digits() !== 16'h1234) $display("FAIL basic_digits: got %h want 1234", digits());
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0 || busy !== 1'b0) $display("FAIL basic_ovf_busy: got ovf %b busy %b want 0 0", overflow, busy);
    else pass_cnt++;
    $display("conv bin=1234 -> %h ovf=%b latency %0d", digits(), overflow, c);
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    bin = 14'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c1);
    total_cnt++;
    if (digits() !== 16'h0000 || c1 != 15) $display("FAIL b2b_first: got %h lat %0d want 0000 lat 15", digits(), c1);
    else pass_cnt++;
    $display("conv bin=0 -> %h", digits());
    bin = 14'd9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c2);
    total_cnt++;
    if (c2 + 1 != 16) $display("FAIL b2b_spacing: got %0d want 16", c2 + 1);
    else pass_cnt++;
    total_cnt++;
    if (digits() !== 16'h9999 || overflow !== 1'b0) $display("FAIL b2b_second: got %h ovf %b want 9999 ovf 0", digits(), overflow);
    else pass_cnt++;
    $display("conv bin=9999 -> %h done gap %0d", digits(), c2 + 1);
  endtask

  task automatic test_overflow();
    int c;
    bin = 14'd12000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c);
    total_cnt++;
    if (digits() !== 16'h9999 || overflow !== 1'b1) $display("FAIL ovf_saturate: got %h ovf %b want 9999 ovf 1", digits(), overflow);
    else pass_cnt++;
    $display("conv bin=12000 -> %h ovf=%b", digits(), overflow);
    bin = 14'd42; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (overflow !== 1'b1 || digits() !== 16'h9999) $display("FAIL ovf_hold: got %h ovf %b want 9999 ovf 1", digits(), overflow);
    else pass_cnt++;
    wait_done(c);
    total_cnt++;
    if (digits() !== 16'h0042 || overflow !== 1'b0) $display("FAIL ovf_clear: got %h ovf %b want 0042 ovf 0", digits(), overflow);
    else pass_cnt++;
    $display("conv bin=42 -> %h ovf=%b", digits(), overflow);
  endtask

  task automatic test_start_held();
    int c;
    bin = 14'd807; start = 1'b1;
    @(negedge clk);
    bin = 14'd5555;
    wait_done(c);
    total_cnt++;
    if (digits() !== 16'h0807 || c != 15) $display("FAIL held_capture: got %h lat %0d want 0807 lat 15", digits(), c);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL held_busy_at_done: got %b want 0", busy);
    else pass_cnt++;
    $display("conv bin=807 (start held) -> %h", digits());
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b1) $display("FAIL held_single_done: got done %b busy %b want 0 1", done, busy);
    else pass_cnt++;
    wait_done(c);
    total_cnt++;
    if (digits() !== 16'h5555 || c != 15) $display("FAIL held_next: got %h lat %0d want 5555 lat 15", digits(), c);
    else pass_cnt++;
    $display("conv bin=5555 -> %h", digits());
  endtask

  task automatic test_reset_abort();
    int c;
    bin = 14'd1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({busy, done, overflow} !== 3'b000) $display("FAIL abort_flags: got %b want 000", {busy, done, overflow});
    else pass_cnt++;
    total_cnt++;
    if (digits() !== 16'h0000) $display("FAIL abort_digits: got %h want 0000", digits());
    else pass_cnt++;
    reset = 1'b0; bin = 14'd4321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c);
    total_cnt++;
    if (digits() !== 16'h4321 || c != 15) $display("FAIL abort_restart: got %h lat %0d want 4321 lat 15", digits(), c);
    else pass_cnt++;
    $display("conv bin=4321 after abort -> %h", digits());
  endtask

  task automatic test_sweep14();
    int t;
    int bad = 0;
    for (int v = 0; v < 2500; v++) begin
      for (int l = 0; l < 4; l++) sw_bin[l] = 14'(v + 2500 * l);
      sw_start = 1'b1;
      @(negedge clk);
      sw_start = 1'b0;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!sw_done[0] && t < 40);
      total_cnt++;
      if (t != 15) begin
        $display("FAIL sweep14_latency v=%0d: got %0d want 15", v, t);
        bad++;
      end else pass_cnt++;
      for (int l = 0; l < 4; l++) begin
        total_cnt++;
        if ({sw_thousands[l], sw_hundreds[l], sw_tens[l], sw_ones[l]} !== to_bcd(v + 2500 * l)) begin
          $display("FAIL sweep14 bin=%0d: got %h want %h", v + 2500 * l,
                   {sw_thousands[l], sw_hundreds[l], sw_tens[l], sw_ones[l]}, to_bcd(v + 2500 * l));
          bad++;
        end else pass_cnt++;
      end
    end
    $display("sweep BIN_W=14 0..9999 done, %0d bad", bad);
  endtask

  task automatic test_sweep4();
    int t;
    for (int v = 0; v < 16; v++) begin
      w4_bin = 4'(v); w4_start = 1'b1;
      @(negedge clk);
      w4_start = 1'b0;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!w4_done && t < 20);
      total_cnt++;
      if ({w4_thousands, w4_hundreds, w4_tens, w4_ones} !== to_bcd(v) || t != 5)
        $display("FAIL sweep4 bin=%0d: got %h lat %0d want %h lat 5", v,
                 {w4_thousands, w4_hundreds, w4_tens, w4_ones}, t, to_bcd(v));
      else pass_cnt++;
      $display("conv4 bin=%0d -> %h", v, {w4_thousands, w4_hundreds, w4_tens, w4_ones});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bin = '0;
    sw_start = 1'b0; w4_start = 1'b0; w4_bin = '0;
    for (int l = 0; l < 4; l++) sw_bin[l] = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_start_held();
    test_reset_abort();
    test_sweep14();
    test_sweep4();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
